// File: rtl/rv32i_wb_pkg.sv
// Shared types and constants for the RV32I write-back stage.
package rv32i_wb_pkg;

   // Write-back data source selector; the reserved code behaves as ALU.
   typedef enum logic [1:0] {
      WB_SRC_ALU  = 2'b00,
      WB_SRC_LOAD = 2'b01,
      WB_SRC_PC4  = 2'b10,
      WB_SRC_RSVD = 2'b11
   } wb_src_e;

   // Load funct3 encodings (iw[14:12]).
   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   // Write-back controller states.
   typedef enum logic {
      S_IDLE      = 1'b0,
      S_WAIT_LOAD = 1'b1
   } wb_state_e;

endpackage

// File: rtl/rv32i_load_align.sv
// Combinational load data alignment, extension and fault detection.
module rv32i_load_align
   import rv32i_wb_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic [31:0]     word,
   input  logic [1:0]      offset,
   input  logic [2:0]      funct3,
   output logic [XLEN-1:0] data,
   output logic            fault
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Pick the addressed byte and halfword out of the aligned word.
   always_comb begin
      byte_sel = word[7:0];
      case (offset)
         2'd0:    byte_sel = word[7:0];
         2'd1:    byte_sel = word[15:8];
         2'd2:    byte_sel = word[23:16];
         default: byte_sel = word[31:24];
      endcase
      half_sel = offset[1] ? word[31:16] : word[15:0];
   end

   // Extend to XLEN per funct3; misaligned or unknown encodings fault.
   always_comb begin
      data  = '0;
      fault = 1'b0;
      case (funct3)
         F3_LB: begin
            data       = {XLEN{byte_sel[7]}};
            data[7:0]  = byte_sel;
         end
         F3_LBU: begin
            data[7:0]  = byte_sel;
         end
         F3_LH: begin
            fault      = offset[0];
            data       = {XLEN{half_sel[15]}};
            data[15:0] = half_sel;
         end
         F3_LHU: begin
            fault      = offset[0];
            data[15:0] = half_sel;
         end
         F3_LW: begin
            fault      = (offset != 2'd0);
            data       = {XLEN{word[31]}};
            data[31:0] = word;
         end
         default: begin
            fault      = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/rv32i_wb_stage.sv
// RV32I write-back stage: result selection, load wait, retire counting.
module rv32i_wb_stage
   import rv32i_wb_pkg::*;
#(
   parameter int unsigned XLEN   = 32,
   parameter int unsigned REG_AW = 5,
   parameter int unsigned CNT_W  = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              valid_in,
   input  logic              wb_en_in,
   input  logic [REG_AW-1:0] wb_reg_in,
   input  logic [1:0]        wb_src_in,
   input  logic [XLEN-1:0]   pc_in,
   input  logic [XLEN-1:0]   iw_in,
   input  logic [XLEN-1:0]   alu_in,
   input  logic [31:0]       mem_rdata_in,
   input  logic              mem_rvalid_in,
   output logic              stall_out,
   output logic              wb_en_out,
   output logic [REG_AW-1:0] wb_reg_out,
   output logic [XLEN-1:0]   wb_data,
   output logic              fault_out,
   output logic [CNT_W-1:0]  retire_cnt
);

   wb_state_e         state_q, state_d;
   wb_src_e           src_in;
   logic              is_load_in;
   logic              in_wait;
   logic              complete;
   logic              start_wait;

   // Fields held across WAIT_LOAD.
   logic              cap_wb_en;
   logic [REG_AW-1:0] cap_reg;
   logic [1:0]        cap_offset;
   logic [2:0]        cap_funct3;

   // Result of the instruction completing this cycle.
   logic              res_wb_en;
   logic [REG_AW-1:0] res_reg;
   logic [XLEN-1:0]   res_data;
   logic              res_fault;

   logic [1:0]        la_offset;
   logic [2:0]        la_funct3;
   logic [XLEN-1:0]   la_data;
   logic              la_fault;

   logic              unused_iw;

   assign src_in     = wb_src_e'(wb_src_in);
   assign is_load_in = (src_in == WB_SRC_LOAD);
   assign in_wait    = (state_q == S_WAIT_LOAD);
   assign stall_out  = in_wait;
   assign unused_iw  = ^{iw_in[XLEN-1:15], iw_in[11:0]};

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state plus accept/complete decode.
   always_comb begin
      state_d    = state_q;
      complete   = 1'b0;
      start_wait = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (valid_in) begin
               if (is_load_in && !mem_rvalid_in) begin
                  start_wait = 1'b1;
                  state_d    = S_WAIT_LOAD;
               end else begin
                  complete   = 1'b1;
               end
            end
         end
         S_WAIT_LOAD: begin
            if (mem_rvalid_in) begin
               complete = 1'b1;
               state_d  = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // While waiting, alignment and destination come from captured fields, not live inputs.
   always_comb begin
      la_offset = in_wait ? cap_offset : alu_in[1:0];
      la_funct3 = in_wait ? cap_funct3 : iw_in[14:12];
      res_wb_en = in_wait ? cap_wb_en  : wb_en_in;
      res_reg   = in_wait ? cap_reg    : wb_reg_in;
      res_data  = alu_in;
      if (in_wait) begin
         res_data = la_data;
      end else begin
         case (src_in)
            WB_SRC_LOAD: res_data = la_data;
            WB_SRC_PC4:  res_data = pc_in + XLEN'(4);
            default:     res_data = alu_in;
         endcase
      end
      res_fault = (in_wait || is_load_in) && la_fault;
   end

   rv32i_load_align #(
      .XLEN (XLEN)
   ) u_load_align (
      .word   (mem_rdata_in),
      .offset (la_offset),
      .funct3 (la_funct3),
      .data   (la_data),
      .fault  (la_fault)
   );

   // Registered outputs and retire counter; strobes default low for one-cycle pulses.
   always_ff @(posedge clk) begin
      if (reset) begin
         wb_en_out  <= 1'b0;
         fault_out  <= 1'b0;
         wb_reg_out <= '0;
         wb_data    <= '0;
         retire_cnt <= '0;
      end else begin
         wb_en_out <= 1'b0;
         fault_out <= 1'b0;
         if (complete) begin
            if (res_fault) begin
               fault_out <= 1'b1;
            end else begin
               retire_cnt <= retire_cnt + CNT_W'(1);
               if (res_wb_en && (res_reg != '0)) begin
                  wb_en_out  <= 1'b1;
                  wb_reg_out <= res_reg;
                  wb_data    <= res_data;
               end
            end
         end
      end
   end

   // Capture load fields when the memory word is not yet available.
   always_ff @(posedge clk) begin
      if (reset) begin
         cap_wb_en  <= 1'b0;
         cap_reg    <= '0;
         cap_offset <= '0;
         cap_funct3 <= '0;
      end else if (start_wait) begin
         cap_wb_en  <= wb_en_in;
         cap_reg    <= wb_reg_in;
         cap_offset <= alu_in[1:0];
         cap_funct3 <= iw_in[14:12];
      end
   end

endmodule
